// File: rtl/fifo_rd_downsizer.sv
// FWFT FIFO read-side downsizer.
// Splits each T-bit word into RATIO beats on a valid/ready stream.
module fifo_rd_downsizer #(
  parameter int T         = 64,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [T-1:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic         flush,
  output logic [T/RATIO-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last
);

  localparam int W  = T / RATIO;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [T-1:0]  hold_q;
  logic [CW-1:0] sel;
  logic          hold_valid;
  logic          fire;
  logic          at_last;
  logic          pop;

  assign hold_valid = (state_q == DRAIN);
  assign fire       = hold_valid && m_ready;
  assign at_last    = hold_valid && (cnt_q == CNT_MAX);

  // Refill on empty, or in the same cycle the last beat leaves.
  assign pop = arst_n && !fifo_empty && !flush &&
               (!hold_valid || (fire && at_last));

  assign fifo_rd_en = pop;
  assign m_valid    = hold_valid;
  assign m_last     = at_last;

  assign sel    = LSB_FIRST ? cnt_q : (CNT_MAX - cnt_q);
  assign m_data = hold_q[sel*W +: W];

  // Next state and beat index; flush beats pop and beat progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (flush) begin
          state_d = EMPTY;
          cnt_d   = '0;
        end else if (pop) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (fire) begin
          if (at_last) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the FIFO head word on every pop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hold_q <= '0;
    end else if (pop) begin
      hold_q <= fifo_dout;
    end
  end

endmodule
